rob_alloc_ctrl: RTL and testbench

Controller that sequences ROB tag allocation, retirement and branch recovery for the out-of-order core. Keeps circular head and tail pointers over 2^ROB_WIDTH ROB entries and grants dispatch allocation only when an entry is free. Holds a FIFO of branch checkpoints so a mispredict rolls the tail back to just after the oldest unresolved branch. Sits between dispatch (requester) and the ROB/commit stage.

---
 rtl/rob_alloc_ctrl.sv | 119 +++++++++++
 tb/tb_rob_alloc_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
// rtl/rob_alloc_ctrl.sv - ROB tag allocation, retirement and branch-checkpoint recovery controller.
// Optional stall/flush statistics counters are built when ROB_ALLOC_STATS_EN is defined.
module rob_alloc_ctrl #(
    parameter int ROB_WIDTH  = 5,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req,
    input  logic                 is_branch_dispatch,
    output logic                 alloc_gnt,
    output logic [ROB_WIDTH-1:0] rob_tag,
    output logic                 rob_full,
    output logic                 rob_empty,
    output logic                 ckpt_full,
    input  logic                 commit_req,
    output logic [ROB_WIDTH-1:0] head_tag,
    input  logic                 branch_resolve,
    input  logic                 branch_mispredict,
    output logic [ROB_WIDTH:0]   rob_count,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);
    localparam int CW = $clog2(CKPT_DEPTH);
    localparam logic [ROB_WIDTH:0] ROB_DEPTH_V = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [CW:0]        CKPT_FULL_V = {1'b1, {CW{1'b0}}};
    localparam logic [ROB_WIDTH:0] PTR_ONE     = (ROB_WIDTH+1)'(1);
    localparam logic [CW:0]        CK_ONE      = (CW+1)'(1);

    logic [ROB_WIDTH:0] head_q, head_d, tail_q, tail_d;
    logic [CW:0]        ck_wr_q, ck_wr_d, ck_rd_q, ck_rd_d;
    logic [ROB_WIDTH:0] ckpt_q [CKPT_DEPTH];
    logic [ROB_WIDTH:0] ckpt_d [CKPT_DEPTH];
    logic               ckpt_empty;
    logic               mispredict_taken;

    assign rob_count  = tail_q - head_q;
    assign rob_full   = (rob_count == ROB_DEPTH_V);
    assign rob_empty  = (rob_count == '0);
    assign ckpt_full  = ((ck_wr_q - ck_rd_q) == CKPT_FULL_V);
    assign ckpt_empty = (ck_wr_q == ck_rd_q);
    assign rob_tag    = tail_q[ROB_WIDTH-1:0];
    assign head_tag   = head_q[ROB_WIDTH-1:0];

    // Mispredict blocks allocation even when no checkpoint is live to restore.
    assign alloc_gnt = reset & alloc_req & ~rob_full & ~branch_mispredict
                     & ~(is_branch_dispatch & ckpt_full);
    assign mispredict_taken = branch_mispredict & ~ckpt_empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        ck_wr_d = ck_wr_q;
        ck_rd_d = ck_rd_q;
        for (int i = 0; i < CKPT_DEPTH; i++) ckpt_d[i] = ckpt_q[i];

        if (commit_req && !rob_empty) head_d = head_q + PTR_ONE;

        if (mispredict_taken) begin
            tail_d  = ckpt_q[ck_rd_q[CW-1:0]];
            ck_rd_d = ck_wr_q;
        end else begin
            if (alloc_gnt) begin
                tail_d = tail_q + PTR_ONE;
                if (is_branch_dispatch) begin
                    ckpt_d[ck_wr_q[CW-1:0]] = tail_q + PTR_ONE;
                    ck_wr_d = ck_wr_q + CK_ONE;
                end
            end
            if (branch_resolve && !ckpt_empty) ck_rd_d = ck_rd_q + CK_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            ck_wr_q <= '0;
            ck_rd_q <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) ckpt_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            ck_wr_q <= ck_wr_d;
            ck_rd_q <= ck_rd_d;
            for (int i = 0; i < CKPT_DEPTH; i++) ckpt_q[i] <= ckpt_d[i];
        end
    end

`ifdef ROB_ALLOC_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (alloc_req && !alloc_gnt && !branch_mispredict && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (mispredict_taken && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb/tb_rob_alloc_ctrl.sv - directed self-checking bench for rob_alloc_ctrl.
module tb_rob_alloc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req, is_branch_dispatch, commit_req, branch_resolve, branch_mispredict;
    logic        alloc_gnt, rob_full, rob_empty, ckpt_full;
    logic [4:0]  rob_tag, head_tag;
    logic [5:0]  rob_count;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ROB_ALLOC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    rob_alloc_ctrl #(.ROB_WIDTH(5), .CKPT_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .is_branch_dispatch(is_branch_dispatch),
        .alloc_gnt(alloc_gnt), .rob_tag(rob_tag), .rob_full(rob_full),
        .rob_empty(rob_empty), .ckpt_full(ckpt_full), .commit_req(commit_req),
        .head_tag(head_tag), .branch_resolve(branch_resolve),
        .branch_mispredict(branch_mispredict), .rob_count(rob_count),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 0; is_branch_dispatch = 0; commit_req = 0;
        branch_resolve = 0; branch_mispredict = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 0;
        #2;
        reset = 1;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        alloc_req = 1;
        #12;
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_tag", rob_tag, 0);
        chk("rst_head", head_tag, 0);
        chk("rst_empty", rob_empty, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_ckfull", ckpt_full, 0);
        chk("rst_count", rob_count, 0);
        do_reset();

        // Test 1: fill all 32 entries
        alloc_req = 1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("t1_gnt%0d", i), alloc_gnt, 1);
            chk($sformatf("t1_tag%0d", i), rob_tag, i);
            tick();
        end
        chk("t1_full", rob_full, 1);
        chk("t1_count", rob_count, 32);
        chk("t1_gnt33", alloc_gnt, 0);
        tick();
        chk("t1_stall", stall_cnt, STATS ? 1 : 0);

        // Test 2: commit on full does not free space this cycle
        commit_req = 1;
        #1;
        chk("t2_gnt_full", alloc_gnt, 0);
        tick();
        commit_req = 0;
        #1;
        chk("t2_head", head_tag, 1);
        chk("t2_count", rob_count, 31);
        chk("t2_gnt", alloc_gnt, 1);
        chk("t2_tag_wrap", rob_tag, 0);
        tick();
        alloc_req = 0;
        chk("t2_count2", rob_count, 32);
        chk("t2_stall", stall_cnt, STATS ? 2 : 0);

        // Test 3: mispredict rolls tail back to just after the branch
        do_reset();
        alloc_req = 1;
        repeat (3) tick();
        is_branch_dispatch = 1;
        tick();
        is_branch_dispatch = 0;
        repeat (4) tick();
        chk("t3_count8", rob_count, 8);
        branch_mispredict = 1;
        #1;
        chk("t3_gnt_blk", alloc_gnt, 0);
        tick();
        idle_inputs();
        #1;
        chk("t3_count", rob_count, 4);
        chk("t3_tag", rob_tag, 4);
        chk("t3_ckfull", ckpt_full, 0);
        chk("t3_flush", flush_cnt, STATS ? 1 : 0);
        chk("t3_stall", stall_cnt, 0);

        // Test 4: checkpoint FIFO full blocks only branches
        do_reset();
        alloc_req = 1; is_branch_dispatch = 1;
        repeat (4) tick();
        chk("t4_ckfull", ckpt_full, 1);
        chk("t4_gnt_br", alloc_gnt, 0);
        is_branch_dispatch = 0;
        #1;
        chk("t4_gnt_nb", alloc_gnt, 1);
        tick();
        chk("t4_tag", rob_tag, 5);
        alloc_req = 0;
        branch_resolve = 1;
        tick();
        branch_resolve = 0;
        #1;
        chk("t4_ckfree", ckpt_full, 0);
        chk("t4_count", rob_count, 5);

        // Test 5: mispredict beats resolve; checkpoints saved at 2 and 5
        do_reset();
        alloc_req = 1;
        tick();
        is_branch_dispatch = 1; tick();
        is_branch_dispatch = 0; repeat (2) tick();
        is_branch_dispatch = 1; tick();
        idle_inputs();
        #1;
        chk("t5_count5", rob_count, 5);
        branch_resolve = 1; branch_mispredict = 1;
        tick();
        idle_inputs();
        #1;
        chk("t5_count", rob_count, 2);
        chk("t5_tag", rob_tag, 2);
        chk("t5_head", head_tag, 0);
        branch_mispredict = 1;
        tick();
        branch_mispredict = 0;
        #1;
        chk("t5_nockpt", rob_count, 2);
        chk("t5_flush", flush_cnt, STATS ? 1 : 0);
        commit_req = 1;
        tick();
        commit_req = 0;
        #1;
        chk("t5_commit_head", head_tag, 1);
        chk("t5_commit_cnt", rob_count, 1);

        // Test 6: asynchronous reset mid-stream
        do_reset();
        alloc_req = 1;
        repeat (10) tick();
        alloc_req = 0;
        #1;
        chk("t6_count10", rob_count, 10);
        @(negedge clk);
        #2;
        alloc_req = 1;
        reset = 0;
        #1;
        chk("t6_count", rob_count, 0);
        chk("t6_empty", rob_empty, 1);
        chk("t6_full", rob_full, 0);
        chk("t6_tag", rob_tag, 0);
        chk("t6_head", head_tag, 0);
        chk("t6_ckfull", ckpt_full, 0);
        chk("t6_gnt", alloc_gnt, 0);
        chk("t6_stall", stall_cnt, 0);
        chk("t6_flush", flush_cnt, 0);
        reset = 1;
        alloc_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
